// File: rtl/io_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_stream_bridge
// Purpose  : Pads-to-CGRA frame streamer with output capture and frame status.
// Revision : 1.0
// ============================================================================
module io_stream_bridge #(
    parameter int DATA_W       = 16,
    parameter int FRAME_LEN    = 4096,
    parameter int CNT_W        = 13,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic              io_clock,
    input  logic              io_reset,
    input  logic [DATA_W-1:0] pad_in_data,
    input  logic              pad_in_start,
    output logic [DATA_W-1:0] cgra_in_data,
    output logic              cgra_in_start,
    output logic              cgra_in_valid,
    input  logic [DATA_W-1:0] cgra_out_data,
    input  logic              cgra_out_valid,
    output logic [DATA_W-1:0] pad_out_data,
    output logic              pad_out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic [DATA_W-1:0] checksum,
    output logic              frame_done,
    output logic              start_err
);

    localparam int IN_W = $clog2(FRAME_LEN + 1);
    localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IN_W-1:0]  IN_LAST = IN_W'(FRAME_LEN);
    localparam logic [DR_W-1:0]  DR_LAST = DR_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] data_q;
    logic              start_q;
    logic              start_qq;
    logic              start_edge;
    logic              launch;
    logic              busy;
    logic [IN_W-1:0]   in_cnt;
    logic [DR_W-1:0]   drain_cnt;

    assign start_edge = start_q & ~start_qq;
    assign busy       = (state == STREAM) || (state == DRAIN);

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // in_cnt reaches FRAME_LEN one cycle after the last word was issued, so the
    // registered valid lines up with the registered data.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_nxt = STREAM;
                    launch    = 1'b1;
                end
            end
            STREAM: begin
                if (in_cnt == IN_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DR_LAST) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            data_q        <= '0;
            start_q       <= 1'b0;
            start_qq      <= 1'b0;
            cgra_in_data  <= '0;
            cgra_in_start <= 1'b0;
            cgra_in_valid <= 1'b0;
            pad_out_data  <= '0;
            pad_out_valid <= 1'b0;
            frame_done    <= 1'b0;
            start_err     <= 1'b0;
            in_cnt        <= '0;
            drain_cnt     <= '0;
            out_count     <= '0;
            checksum      <= '0;
        end else begin
            data_q        <= pad_in_data;
            start_q       <= pad_in_start;
            start_qq      <= start_q;
            cgra_in_data  <= data_q;
            cgra_in_start <= launch;
            cgra_in_valid <= (state == STREAM) && (in_cnt != IN_LAST);
            pad_out_data  <= cgra_out_data;
            pad_out_valid <= cgra_out_valid;
            frame_done    <= (state_nxt == DONE);

            if (busy && start_edge) begin
                start_err <= 1'b1;
            end

            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + DR_W'(1);
            end else begin
                drain_cnt <= '0;
            end

            if (launch) begin
                in_cnt    <= '0;
                out_count <= '0;
                checksum  <= '0;
            end else begin
                if (state == STREAM && in_cnt != IN_LAST) begin
                    in_cnt <= in_cnt + IN_W'(1);
                end
                if (busy && cgra_out_valid) begin
                    if (out_count != CNT_MAX) begin
                        out_count <= out_count + CNT_W'(1);
                    end
                    checksum <= checksum + cgra_out_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_stream_bridge
// Purpose  : Directed + random bench for two io_stream_bridge configurations.
// Revision : 1.0
// ============================================================================
module tb_io_stream_bridge;

    localparam int MAXC = 2048;
    localparam int FL_A = 16;
    localparam int D_A  = 4;
    localparam int CW_A = 5;
    localparam int FL_B = 4;
    localparam int D_B  = 8;
    localparam int CW_B = 3;

    logic        io_clock = 1'b0;
    logic        io_reset;
    logic [15:0] pad_in_data;
    logic        pad_in_start;
    logic [15:0] cgra_out_data;
    logic        cgra_out_valid;

    logic [15:0]     a_in_data, b_in_data;
    logic            a_in_start, b_in_start;
    logic            a_in_valid, b_in_valid;
    logic [15:0]     a_pad_data, b_pad_data;
    logic            a_pad_valid, b_pad_valid;
    logic [CW_A-1:0] a_count;
    logic [CW_B-1:0] b_count;
    logic [15:0]     a_sum, b_sum;
    logic            a_done, b_done;
    logic            a_err, b_err;

    always #5 io_clock = ~io_clock;

    io_stream_bridge #(.DATA_W(16), .FRAME_LEN(FL_A), .CNT_W(CW_A), .DRAIN_CYCLES(D_A)) dut_a (
        .io_clock(io_clock), .io_reset(io_reset),
        .pad_in_data(pad_in_data), .pad_in_start(pad_in_start),
        .cgra_in_data(a_in_data), .cgra_in_start(a_in_start), .cgra_in_valid(a_in_valid),
        .cgra_out_data(cgra_out_data), .cgra_out_valid(cgra_out_valid),
        .pad_out_data(a_pad_data), .pad_out_valid(a_pad_valid),
        .out_count(a_count), .checksum(a_sum), .frame_done(a_done), .start_err(a_err)
    );

    io_stream_bridge #(.DATA_W(16), .FRAME_LEN(FL_B), .CNT_W(CW_B), .DRAIN_CYCLES(D_B)) dut_b (
        .io_clock(io_clock), .io_reset(io_reset),
        .pad_in_data(pad_in_data), .pad_in_start(pad_in_start),
        .cgra_in_data(b_in_data), .cgra_in_start(b_in_start), .cgra_in_valid(b_in_valid),
        .cgra_out_data(cgra_out_data), .cgra_out_valid(cgra_out_valid),
        .pad_out_data(b_pad_data), .pad_out_valid(b_pad_valid),
        .out_count(b_count), .checksum(b_sum), .frame_done(b_done), .start_err(b_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rend     = 0;

    // Stimulus history, indexed by the cycle in which it was driven.
    logic        h_rst   [MAXC];
    logic        h_start [MAXC];
    logic [15:0] h_pad   [MAXC];
    logic        h_ov    [MAXC];
    logic [15:0] h_od    [MAXC];

    // Frame-level reference: S = cycle of the accepted start edge, -1 if none.
    int fl_v [2] = '{FL_A, FL_B};
    int dr_v [2] = '{D_A, D_B};
    int cmax [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    int m_s  [2] = '{-1, -1};
    int m_cnt[2] = '{0, 0};
    int m_sum[2] = '{0, 0};
    bit m_err[2] = '{1'b0, 1'b0};

    function automatic bit valid_idx(input int k);
        return (k >= 0) && (k >= rend);
    endfunction

    function automatic logic hs(input int k);
        return valid_idx(k) ? h_start[k] : 1'b0;
    endfunction

    function automatic logic [15:0] hp(input int k);
        return valid_idx(k) ? h_pad[k] : 16'h0000;
    endfunction

    function automatic logic hov(input int k);
        return valid_idx(k) ? h_ov[k] : 1'b0;
    endfunction

    function automatic logic [15:0] hod(input int k);
        return valid_idx(k) ? h_od[k] : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic [15:0] o_id, input logic o_st,
                              input logic o_v, input logic [15:0] o_pd, input logic o_pv,
                              input logic [15:0] o_cnt, input logic [15:0] o_sum,
                              input logic o_done, input logic o_err);
        string p;
        int    s;
        bit    act;
        int    ec;
        p   = (i == 0) ? "a" : "b";
        s   = m_s[i];
        act = (s >= 0);
        ec  = (m_cnt[i] > cmax[i]) ? cmax[i] : m_cnt[i];
        chk({p, ".in_start"},  16'(o_st),   16'(act && cyc == s + 1));
        chk({p, ".in_valid"},  16'(o_v),    16'(act && cyc >= s + 2 && cyc <= s + fl_v[i] + 1));
        chk({p, ".in_data"},   o_id,        hp(cyc - 2));
        chk({p, ".pad_data"},  o_pd,        hod(cyc - 1));
        chk({p, ".pad_valid"}, 16'(o_pv),   16'(hov(cyc - 1)));
        chk({p, ".out_count"}, o_cnt,       16'(ec));
        chk({p, ".checksum"},  o_sum,       16'(m_sum[i]));
        chk({p, ".done"},      16'(o_done), 16'(act && cyc >= s + fl_v[i] + dr_v[i] + 2));
        chk({p, ".start_err"}, 16'(o_err),  16'(m_err[i]));
    endtask

    task automatic model_update(input int i);
        int  s;
        bit  busy;
        bit  edge_now;
        s        = m_s[i];
        busy     = (s >= 0) && (cyc >= s + 1) && (cyc <= s + fl_v[i] + dr_v[i] + 1);
        edge_now = hs(cyc - 1) && !hs(cyc - 2);
        if (busy && h_ov[cyc]) begin
            m_cnt[i] = m_cnt[i] + 1;
            m_sum[i] = (m_sum[i] + int'(h_od[cyc])) % 65536;
        end
        if (edge_now) begin
            if (busy) begin
                m_err[i] = 1'b1;
            end else begin
                m_s[i]   = cyc;
                m_cnt[i] = 0;
                m_sum[i] = 0;
            end
        end
        if (h_rst[cyc]) begin
            m_s[i]   = -1;
            m_cnt[i] = 0;
            m_sum[i] = 0;
            m_err[i] = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic st, input logic [15:0] pd,
                        input logic ov, input logic [15:0] od);
        io_reset       = r;
        pad_in_start   = st;
        pad_in_data    = pd;
        cgra_out_valid = ov;
        cgra_out_data  = od;
        h_rst[cyc]   = r;
        h_start[cyc] = st;
        h_pad[cyc]   = pd;
        h_ov[cyc]    = ov;
        h_od[cyc]    = od;
        @(negedge io_clock);
        check_inst(0, a_in_data, a_in_start, a_in_valid, a_pad_data, a_pad_valid,
                   16'(a_count), a_sum, a_done, a_err);
        check_inst(1, b_in_data, b_in_start, b_in_valid, b_pad_data, b_pad_valid,
                   16'(b_count), b_sum, b_done, b_err);
        model_update(0);
        model_update(1);
        if (r) rend = cyc + 1;
        @(posedge io_clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic st);
        for (int k = 0; k < n; k++) begin
            step(1'b0, st, 16'($urandom), 1'b0, 16'h0000);
        end
    endtask

    logic [15:0] cap_data [5] = '{16'h8000, 16'h8000, 16'h0001, 16'h0002, 16'h0003};

    initial begin
        int ci;
        io_reset       = 1'b1;
        pad_in_start   = 1'b0;
        pad_in_data    = '0;
        cgra_out_valid = 1'b0;
        cgra_out_data  = '0;
        @(posedge io_clock);
        #1;

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'($urandom), 1'b0, 16'h0000);
        idle(3, 1'b0);

        // Nominal frame: words 0..15, five captured outputs.
        step(1'b0, 1'b1, 16'($urandom), 1'b0, 16'h0000);
        ci = 0;
        for (int n = 0; n < 16; n++) begin
            if (n >= 2 && n <= 10 && (n % 2) == 0) begin
                step(1'b0, 1'b0, 16'(n), 1'b1, cap_data[ci]);
                ci++;
            end else begin
                step(1'b0, 1'b0, 16'(n), 1'b0, 16'h0000);
            end
        end
        idle(12, 1'b0);
        chk("nominal.a.count",    16'(a_count), 16'd5);
        chk("nominal.a.checksum", a_sum,        16'h0006);
        chk("nominal.a.done",     16'(a_done),  16'd1);
        chk("nominal.b.count",    16'(b_count), 16'd5);

        // Second start edge while busy, at in_cnt = 5.
        step(1'b0, 1'b1, 16'($urandom), 1'b0, 16'h0000);
        idle(5, 1'b0);
        step(1'b0, 1'b1, 16'($urandom), 1'b0, 16'h0000);
        idle(30, 1'b0);
        chk("busy.a.start_err", 16'(a_err), 16'd1);
        chk("busy.b.start_err", 16'(b_err), 16'd1);

        // Reset mid-STREAM.
        step(1'b0, 1'b1, 16'($urandom), 1'b0, 16'h0000);
        idle(8, 1'b0);
        step(1'b1, 1'b0, 16'($urandom), 1'b1, 16'h1234);
        idle(6, 1'b0);
        chk("reset.a.start_err", 16'(a_err),      16'd0);
        chk("reset.a.in_valid",  16'(a_in_valid), 16'd0);

        // Wrap and saturation; the output in the start-edge cycle is not counted.
        step(1'b0, 1'b1, 16'($urandom), 1'b0, 16'h0000);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 16'($urandom), 1'b1, 16'hFFFF);
        idle(25, 1'b0);
        chk("sat.b.count",    16'(b_count), 16'd7);
        chk("sat.b.checksum", b_sum,        16'hFFF7);
        chk("sat.a.count",    16'(a_count), 16'd9);
        chk("sat.a.checksum", a_sum,        16'hFFF7);

        // Held start gives one frame; a fresh rising edge in DONE restarts.
        for (int k = 0; k < 30; k++)
            step(1'b0, 1'b1, 16'($urandom), 1'($urandom), 16'($urandom));
        idle(2, 1'b0);
        for (int k = 0; k < 30; k++)
            step(1'b0, 1'b1, 16'($urandom), 1'($urandom), 16'($urandom));
        idle(2, 1'b0);

        // Start level held through reset release.
        step(1'b1, 1'b1, 16'($urandom), 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'($urandom), 1'b0, 16'h0000);
        for (int k = 0; k < 25; k++)
            step(1'b0, 1'b1, 16'($urandom), 1'($urandom), 16'($urandom));
        idle(2, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 19) == 0),
                 16'($urandom), 1'($urandom), 16'($urandom));
        end
        idle(30, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_stream_bridge.md
# io_stream_bridge

Frame-level streaming bridge between the user-project GPIO pads and the CGRA array's IO tiles. It registers the 16-bit input stream and start strobe from the pads, then replays one frame of FRAME_LEN words into the CGRA with a start pulse and a valid qualifier. It registers the CGRA's output stream back onto the pads and accumulates per-frame status (output count, checksum, done, error) for the management core's message pins.

## Interface
Parameters:
- DATA_W, 16, stream word width.
- FRAME_LEN, 4096, input words per frame.
- CNT_W, 13, counter width; must satisfy 2^CNT_W > FRAME_LEN.
- DRAIN_CYCLES, 64, cycles to keep capturing outputs after the last input word.

Ports:
- io_clock, in, 1, single clock for all logic.
- io_reset, in, 1, synchronous, active-high reset.
- pad_in_data, in, DATA_W, input word from pads; unsynchronised.
- pad_in_start, in, 1, frame start strobe from pads; level or pulse.
- cgra_in_data, out, DATA_W, word to CGRA input IO tile.
- cgra_in_start, out, 1, one-cycle frame start to CGRA.
- cgra_in_valid, out, 1, qualifies cgra_in_data.
- cgra_out_data, in, DATA_W, CGRA output word.
- cgra_out_valid, in, 1, qualifies cgra_out_data.
- pad_out_data, out, DATA_W, registered copy of cgra_out_data.
- pad_out_valid, out, 1, registered copy of cgra_out_valid.
- out_count, out, CNT_W, valid outputs seen this frame; saturating.
- checksum, out, DATA_W, sum mod 2^DATA_W of valid outputs this frame.
- frame_done, out, 1, high in DONE.
- start_err, out, 1, sticky flag: a start edge arrived while busy.

## Operation
- Input stage: pad_in_data and pad_in_start are registered every cycle into data_q and start_q. start_q is also delayed into start_qq. Start edge E = start_q & ~start_qq.
- States:
  - IDLE: waiting for a start edge. E -> STREAM; clears out_count, checksum and in_cnt.
  - STREAM: in_cnt counts 0..FRAME_LEN-1 while feeding words. After the last word -> DRAIN.
  - DRAIN: drain_cnt counts 0..DRAIN_CYCLES-1. After the last count -> DONE.
  - DONE: waiting for the next frame. E -> STREAM; clears out_count, checksum, in_cnt and frame_done.
- cgra_in_data <= data_q every cycle, regardless of state.
- cgra_in_valid is high in the cycles where STREAM is presenting in_cnt 0..FRAME_LEN-1 on cgra_in_data.
- Output path: pad_out_data <= cgra_out_data and pad_out_valid <= cgra_out_valid every cycle, in all states.
- Counting: in STREAM and DRAIN, each cgra_out_valid cycle does out_count += 1 and checksum += cgra_out_data. out_count saturates at 2^CNT_W-1, while checksum keeps wrapping. Outputs in IDLE or DONE are forwarded to the pads but not counted.
- start_err: set when E occurs in STREAM or DRAIN. That edge is otherwise ignored. Cleared only by io_reset.
- Reset, applied at any time including mid-frame:
  - State returns to IDLE.
  - All outputs go to 0: cgra_in_data, cgra_in_start, cgra_in_valid, pad_out_data, pad_out_valid, out_count, checksum, frame_done, start_err.
  - data_q, start_q and start_qq are also cleared.
  - A start level held high through reset release produces an edge one cycle after release.

## Timing
- Cycle numbering: pad values sampled at edge k appear in data_q/start_q in cycle k+1.
- Let cycle S be the first cycle with E=1.
- cgra_in_start = 1 in cycle S+1 only.
- cgra_in_valid = 1 in cycles S+2 .. S+FRAME_LEN+1.
- The word on the pads at the sampling edge one cycle after the start edge is word 0. It appears on cgra_in_data in cycle S+2; word n appears in cycle S+2+n.
- DRAIN spans cycles S+FRAME_LEN+2 .. S+FRAME_LEN+DRAIN_CYCLES+1.
- frame_done rises in cycle S+FRAME_LEN+DRAIN_CYCLES+2.
- Output path latency is 1 cycle from cgra_out_* to pad_out_*.
- out_count and checksum update 1 cycle after the counted cgra_out_valid cycle.
- In the cycle the state enters STREAM, the counters are cleared. An output arriving in the cycle of E is not counted.
- Back-to-back frames: E in DONE in cycle T gives cgra_in_start at T+1, exactly as from IDLE.

## Test plan
- Reset: pulse io_reset mid-STREAM with in_cnt=100. Next cycle: state IDLE, every output 0, cgra_in_valid stays 0 until a new start edge.
- Nominal frame: FRAME_LEN=16, DRAIN_CYCLES=4, pad words 0x0000..0x000F after a one-cycle start pulse. Require cgra_in_start at S+1, words 0..15 with valid at S+2..S+17, and frame_done at S+22.
- Output capture: during the frame, drive cgra_out_valid on 5 cycles with data 0x8000, 0x8000, 0x0001, 0x0002, 0x0003. Require out_count=5, checksum=0x0006, and each word on pad_out_data one cycle later.
- Wrap and saturation: CNT_W=3, 9 valid outputs of 0xFFFF. Require out_count=7 (saturated) and checksum=0xFFF7.
- Start during busy: second start edge at in_cnt=5. Require start_err=1, no second cgra_in_start, and frame length still 16.
- Held start and restart: pad_in_start held high across the frame gives exactly one frame. A new 0->1 transition in DONE clears frame_done, out_count and checksum, and starts frame 2 with cgra_in_start at T+1.
